// File: rtl/rr_arb32_sched.sv
// 32-client round-robin arbiter: registered grant held until ack, with an optional
// bounded lock burst and revocation when the granted client drops its request.
module rr_arb32_sched #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      req,
    input  logic [31:0]      mask,
    input  logic             ack,
    input  logic             lock,
    output logic             gnt_valid,
    output logic [31:0]      gnt_onehot,
    output logic [4:0]       gnt_idx,
    output logic [CNT_W-1:0] burst_cnt,
    output logic             drop_err
);

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    localparam logic [CNT_W:0] MaxBurstW = (CNT_W + 1)'(MAX_BURST);

    state_e       state;
    logic [4:0]   ptr;

    logic [31:0]  elig;
    logic [31:0]  srch_vec;
    logic [4:0]   srch_ptr;
    logic [4:0]   ptr_rel;
    logic [5:0]   hi_res;
    logic [5:0]   lo_res;
    logic         win_vld;
    logic [4:0]   win_idx;
    logic [CNT_W:0] burst_inc;
    logic         burst_more;

    // Lowest-index priority encoder: returns {found, index}.
    function automatic logic [5:0] pencoder32_5(input logic [31:0] v);
        logic [5:0] res;
        res = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 5'(i)};
        end
        return res;
    endfunction

    assign elig    = req & mask;
    assign ptr_rel = gnt_idx + 5'd1;

    // While a grant is held, the search pre-computes the winner after a release.
    always_comb begin
        srch_vec = elig;
        srch_ptr = ptr;
        if (gnt_valid) begin
            srch_vec = elig & ~gnt_onehot;
            srch_ptr = ptr_rel;
        end
    end

    assign hi_res  = pencoder32_5(srch_vec & (32'hFFFF_FFFF << srch_ptr));
    assign lo_res  = pencoder32_5(srch_vec);
    assign win_vld = hi_res[5] | lo_res[5];
    assign win_idx = hi_res[5] ? hi_res[4:0] : lo_res[4:0];

    assign burst_inc  = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_more = lock && (burst_inc < MaxBurstW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            ptr        <= 5'd0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= 32'd0;
            gnt_idx    <= 5'd0;
            burst_cnt  <= '0;
            drop_err   <= 1'b0;
        end else begin
            drop_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (win_vld) begin
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= 32'd1 << win_idx;
                        state      <= StGrant;
                    end
                end
                StGrant, StLocked: begin
                    if (ack) begin
                        if (burst_more) begin
                            burst_cnt <= burst_inc[CNT_W-1:0];
                            state     <= StLocked;
                        end else begin
                            ptr       <= ptr_rel;
                            burst_cnt <= '0;
                            if (win_vld) begin
                                gnt_idx    <= win_idx;
                                gnt_onehot <= 32'd1 << win_idx;
                                state      <= StGrant;
                            end else begin
                                gnt_valid  <= 1'b0;
                                gnt_idx    <= 5'd0;
                                gnt_onehot <= 32'd0;
                                state      <= StIdle;
                            end
                        end
                    end else if (!req[gnt_idx]) begin
                        gnt_valid  <= 1'b0;
                        gnt_idx    <= 5'd0;
                        gnt_onehot <= 32'd0;
                        burst_cnt  <= '0;
                        drop_err   <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb32_sched.sv
// Scoreboard bench for rr_arb32_sched: directed scenarios plus random traffic checked
// against a rotating-search reference model.
module tb_rr_arb32_sched;

    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      req = '0;
    logic [31:0]      mask = '1;
    logic             ack = 1'b0;
    logic             lock = 1'b0;
    logic             gnt_valid;
    logic [31:0]      gnt_onehot;
    logic [4:0]       gnt_idx;
    logic [CNT_W-1:0] burst_cnt;
    logic             drop_err;

    rr_arb32_sched #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mask       (mask),
        .ack        (ack),
        .lock       (lock),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .burst_cnt  (burst_cnt),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [4:0]       idx;
        logic [31:0]      oh;
        logic [CNT_W-1:0] bc;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_valid;
    int   m_idx;
    int   m_ptr;
    int   m_burst;
    bit   m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Rotating search starting at p: the first eligible client in round-robin order.
    function automatic int rr_find(input logic [31:0] e, input int p);
        for (int k = 0; k < 32; k++) begin
            if (e[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    function automatic exp_t model_out();
        exp_t o;
        o.v   = m_valid;
        o.idx = m_valid ? 5'(m_idx) : 5'd0;
        o.oh  = m_valid ? (32'd1 << m_idx) : 32'd0;
        o.bc  = CNT_W'(m_burst);
        o.err = m_err;
        return o;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_burst = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [31:0] r, input logic [31:0] mk,
                              input logic a, input logic l);
        logic [31:0] e;
        int w;
        e = r & mk;
        m_err = 0;
        if (!m_valid) begin
            w = rr_find(e, m_ptr);
            if (w >= 0) begin m_valid = 1; m_idx = w; end
        end else if (a) begin
            if (l && (m_burst + 1 < MAX_BURST)) begin
                m_burst++;
            end else begin
                m_ptr   = (m_idx + 1) % 32;
                m_burst = 0;
                e[m_idx] = 1'b0;
                w = rr_find(e, m_ptr);
                if (w >= 0) m_idx = w;
                else begin m_valid = 0; m_idx = 0; end
            end
        end else if (!r[m_idx]) begin
            m_valid = 0; m_idx = 0; m_burst = 0; m_err = 1;
        end
    endtask

    // Drive one cycle's inputs at the falling edge, queue the expected response,
    // and return just after the following rising edge.
    task automatic step(input logic [31:0] r, input logic [31:0] mk,
                        input logic a, input logic l);
        @(negedge clk);
        req = r; mask = mk; ack = a; lock = l;
        model_step(r, mk, a, l);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_valid", 64'(gnt_valid), 64'd0);
        check("rst_onehot", 64'(gnt_onehot), 64'd0);
        check("rst_idx", 64'(gnt_idx), 64'd0);
        check("rst_burst", 64'(burst_cnt), 64'd0);
        check("rst_drop", 64'(drop_err), 64'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        reset = 1'b0;
        req = '0; mask = '1; ack = 1'b0; lock = 1'b0;
    endtask

    task automatic expect_grant(input string name, input logic v, input logic [4:0] idx);
        check({name, "_valid"}, 64'(gnt_valid), 64'(v));
        check({name, "_idx"}, 64'(gnt_idx), 64'(idx));
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_valid", 64'(gnt_valid), 64'(e.v));
                check("sb_idx", 64'(gnt_idx), 64'(e.idx));
                check("sb_onehot", 64'(gnt_onehot), 64'(e.oh));
                check("sb_burst", 64'(burst_cnt), 64'(e.bc));
                check("sb_drop", 64'(drop_err), 64'(e.err));
            end
        end
    end

    initial begin
        logic [31:0] r, mk;
        logic [4:0]  seq_idx [5];
        seq_idx[0] = 5'd0; seq_idx[1] = 5'd4; seq_idx[2] = 5'd31;
        seq_idx[3] = 5'd0; seq_idx[4] = 5'd4;

        do_reset();

        // Single request, then ack with nothing left
        step(32'h1, '1, 1'b0, 1'b0);
        expect_grant("t1_grant", 1'b1, 5'd0);
        step(32'h1, '1, 1'b1, 1'b0);
        expect_grant("t1_release", 1'b0, 5'd0);

        // Back-to-back with wrap from 31 to 0
        do_reset();
        step(32'h8000_0011, '1, 1'b0, 1'b0);
        expect_grant("t2_seq0", 1'b1, seq_idx[0]);
        for (int i = 1; i < 5; i++) begin
            step(32'h8000_0011, '1, 1'b1, 1'b0);
            expect_grant("t2_seq", 1'b1, seq_idx[i]);
        end

        // Masked client never granted
        do_reset();
        step(32'h6, 32'h4, 1'b0, 1'b0);
        expect_grant("t3_grant", 1'b1, 5'd2);
        step(32'h6, 32'h4, 1'b1, 1'b0);
        expect_grant("t3_empty", 1'b0, 5'd0);
        step(32'h6, 32'h4, 1'b0, 1'b0);
        expect_grant("t3_regrant", 1'b1, 5'd2);

        // Locked burst with forced release
        do_reset();
        step(32'h108, '1, 1'b0, 1'b0);
        expect_grant("t4_first", 1'b1, 5'd3);
        for (int i = 1; i <= 3; i++) begin
            step(32'h108, '1, 1'b1, 1'b1);
            expect_grant("t4_hold", 1'b1, 5'd3);
            check("t4_burst", 64'(burst_cnt), 64'(i));
        end
        step(32'h108, '1, 1'b1, 1'b1);
        expect_grant("t4_forced", 1'b1, 5'd8);
        check("t4_burst_clr", 64'(burst_cnt), 64'd0);

        // Requester drop revokes the grant; pointer kept
        do_reset();
        step(32'h21, '1, 1'b0, 1'b0);
        step(32'h21, '1, 1'b1, 1'b0);
        expect_grant("t5_grant5", 1'b1, 5'd5);
        step(32'h01, '1, 1'b0, 1'b0);
        expect_grant("t5_revoked", 1'b0, 5'd0);
        check("t5_drop_pulse", 64'(drop_err), 64'd1);
        step(32'h21, '1, 1'b0, 1'b0);
        expect_grant("t5_regrant", 1'b1, 5'd5);
        check("t5_drop_clr", 64'(drop_err), 64'd0);

        // Reset in the middle of a locked burst
        do_reset();
        step(32'h8, '1, 1'b0, 1'b0);
        step(32'h8, '1, 1'b1, 1'b1);
        step(32'h8, '1, 1'b1, 1'b1);
        check("t6_burst", 64'(burst_cnt), 64'd2);
        do_reset();
        step(32'hFFFF_FFFF, '1, 1'b0, 1'b0);
        expect_grant("t6_after_rst", 1'b1, 5'd0);

        // Random traffic
        r  = $urandom & $urandom;
        mk = '1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: r = $urandom & $urandom;
                    1: r = 32'd1 << $urandom_range(0, 31);
                    default: r = r | (32'd1 << $urandom_range(0, 31));
                endcase
            end
            if ($urandom_range(0, 15) == 0) begin
                mk = ($urandom_range(0, 1) == 0) ? '1 : ($urandom | $urandom);
            end
            step(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb32_sched.md
Name: rr_arb32_sched

Overview:
- 32-requester round-robin arbiter and scheduler that shares one downstream resource (bus port, issue slot, or write port) among up to 32 clients.
- Built around two `pencoder32_5` lowest-index priority searches:
  - one search over requests at or above the round-robin pointer;
  - one search over all requests, used for wrap-around.
- Grant is registered and held until the resource acknowledges it.
- Optional lock extends a grant into a bounded burst.

Parameters:
- MAX_BURST, 4: maximum consecutive acks a locked requester may hold before the lock is ignored. Legal range 1..15.
- CNT_W, 4: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  32  request vector; bit i = client i requests.
- mask  in  32  enable vector; a client with mask[i]=0 is never newly granted.
- ack  in  1  resource accepted the current grant this cycle. Ignored when gnt_valid=0.
- lock  in  1  sampled with ack: 1 = the granted client continues a burst.
- gnt_valid  out  1  a grant is presented.
- gnt_onehot  out  32  one-hot grant. All zero when gnt_valid=0.
- gnt_idx  out  5  index of the granted client. Equals 0 when gnt_valid=0.
- burst_cnt  out  CNT_W  acks taken in the current locked burst.
- drop_err  out  1  one-cycle pulse: the granted client dropped req before ack.

Behaviour:
- Reset (asynchronous, immediate):
  - gnt_valid=0, gnt_onehot=0, gnt_idx=0, burst_cnt=0, drop_err=0.
  - Pointer ptr=0; state=IDLE.
- Eligible vector E = req & mask.
- Winner search:
  - Hi search = lowest set bit of E & (32'hFFFFFFFF << ptr).
  - If Hi is empty, Lo search = lowest set bit of E.
  - No winner if E=0.
- States:
  - IDLE: if E!=0, register the winner at the next edge (gnt_valid=1, gnt_idx, gnt_onehot), go to GRANT. Latency from req rising to gnt_valid = 1 cycle.
  - GRANT:
    - Outputs are stable until ack.
    - ack & ~lock: ptr <= gnt_idx+1 (mod 32, so 31 wraps to 0); burst_cnt <= 0. In the same cycle, arbitrate again using E with the acked bit cleared and the new ptr. If there is a winner, present it next cycle and stay in GRANT; otherwise go to IDLE with gnt_valid=0.
    - ack & lock & (burst_cnt+1 < MAX_BURST): burst_cnt <= burst_cnt+1; ptr unchanged; grant held; go to LOCKED.
    - ack & lock & (burst_cnt+1 >= MAX_BURST): treat as ack & ~lock (forced release, fairness).
  - LOCKED: same transition rules as GRANT. burst_cnt is nonzero in this state.
- Back-to-back throughput: one grant per cycle is sustained when acks are continuous.
- Requester drop:
  - In GRANT/LOCKED with req[gnt_idx]=0 and ack=0: revoke the grant. Next cycle gnt_valid=0, drop_err=1 for one cycle, burst_cnt=0, ptr unchanged, state IDLE.
  - If ack=1 in the same cycle as the drop, the ack wins and no error is flagged.
- mask changes do not revoke an existing grant. Only new winner searches see mask.
- ack while gnt_valid=0 is ignored and causes no state change.
- Reset asserted mid-burst or mid-grant drops the grant immediately (asynchronously). Arbitration restarts from ptr=0 after reset deasserts.
- gnt_onehot always equals 1<<gnt_idx when gnt_valid=1.

Test Plan:
- Reset, then req=32'h0000_0001 -> gnt_valid=1, gnt_idx=0 one cycle later. Ack -> ptr=1, gnt_valid=0 the next cycle.
- req=32'h8000_0011 held, ack every cycle -> grant sequence 0, 4, 31, 0, 4 (wrap from 31 to 0), with no idle cycles between grants.
- req=32'h0000_0006, mask=32'h0000_0004 -> only idx 2 is granted. Bit 1 is never granted while masked.
- MAX_BURST=4, client 3 holds lock=1 with ack every cycle, and req=32'h0000_0108 -> burst_cnt steps 1, 2, 3; the 4th ack forces release; next grant is idx 8.
- Grant presented to idx 5, then req[5] drops with ack=0 -> gnt_valid=0 next cycle, drop_err pulses for 1 cycle, ptr unchanged (req=32'h20 re-grants idx 5).
- Reset asserted mid-LOCKED burst -> all outputs 0 immediately. After release with req=32'hFFFF_FFFF -> grant idx 0.
